multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 77 +++++++
 rtl/multicycle_ctrl_opcode_decode.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_pkg
//  Description : Shared encodings for the multicycle control unit: FSM
//                state codes, opcode constants, instruction classes,
//                immediate formats and datapath mux select codes.
//  Revision    : 1.0  initial release
// ============================================================================
package multicycle_ctrl_pkg;

  // FSM state codes; the numeric values are visible on the debug port
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // Instruction classes produced by the opcode decoder
  typedef enum logic [3:0] {
    CLS_OP      = 4'd0,
    CLS_OPIMM   = 4'd1,
    CLS_LUI     = 4'd2,
    CLS_AUIPC   = 4'd3,
    CLS_JAL     = 4'd4,
    CLS_JALR    = 4'd5,
    CLS_BRANCH  = 4'd6,
    CLS_LOAD    = 4'd7,
    CLS_STORE   = 4'd8,
    CLS_ILLEGAL = 4'd9
  } op_class_t;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;

  // Immediate formats; must agree with the immediate generator
  localparam logic [2:0] c_IMM_NONE = 3'd0;
  localparam logic [2:0] c_IMM_I    = 3'd1;
  localparam logic [2:0] c_IMM_S    = 3'd2;
  localparam logic [2:0] c_IMM_B    = 3'd3;
  localparam logic [2:0] c_IMM_U    = 3'd4;
  localparam logic [2:0] c_IMM_J    = 3'd5;

  // PC source select
  localparam logic [1:0] c_PC_PLUS4  = 2'd0;
  localparam logic [1:0] c_PC_BRANCH = 2'd1;
  localparam logic [1:0] c_PC_ALU    = 2'd2;

  // Register-file write-back select
  localparam logic [1:0] c_WB_ALU = 2'd0;
  localparam logic [1:0] c_WB_MEM = 2'd1;
  localparam logic [1:0] c_WB_PC4 = 2'd2;

  // ALU operand selects
  localparam logic [1:0] c_ALUA_RS1  = 2'd0;
  localparam logic [1:0] c_ALUA_PC   = 2'd1;
  localparam logic [1:0] c_ALUA_ZERO = 2'd2;
  localparam logic       c_ALUB_RS2  = 1'b0;
  localparam logic       c_ALUB_IMM  = 1'b1;

  // True for classes that take the MEM state
  function automatic logic is_mem_class(input op_class_t cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_opcode_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_opcode_decode
//  Description : Combinational opcode decoder: maps inst[6:0] to an
//                instruction class, its immediate format and an illegal flag.
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_opcode_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [3:0] o_class,
  output logic [2:0] o_imm_type,
  output logic       o_illegal
);

  op_class_t w_class;

  // Opcode lookup; anything unlisted is flagged illegal
  always_comb begin
    w_class    = CLS_ILLEGAL;
    o_imm_type = c_IMM_NONE;
    case (i_opcode)
      c_OPC_LUI:    begin w_class = CLS_LUI;    o_imm_type = c_IMM_U;    end
      c_OPC_AUIPC:  begin w_class = CLS_AUIPC;  o_imm_type = c_IMM_U;    end
      c_OPC_JAL:    begin w_class = CLS_JAL;    o_imm_type = c_IMM_J;    end
      c_OPC_JALR:   begin w_class = CLS_JALR;   o_imm_type = c_IMM_I;    end
      c_OPC_BRANCH: begin w_class = CLS_BRANCH; o_imm_type = c_IMM_B;    end
      c_OPC_LOAD:   begin w_class = CLS_LOAD;   o_imm_type = c_IMM_I;    end
      c_OPC_STORE:  begin w_class = CLS_STORE;  o_imm_type = c_IMM_S;    end
      c_OPC_OPIMM:  begin w_class = CLS_OPIMM;  o_imm_type = c_IMM_I;    end
      c_OPC_OP:     begin w_class = CLS_OP;     o_imm_type = c_IMM_NONE; end
      default:      begin w_class = CLS_ILLEGAL; o_imm_type = c_IMM_NONE; end
    endcase
  end

  assign o_class   = w_class;
  assign o_illegal = (w_class == CLS_ILLEGAL);

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multicycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
//                State is registered; datapath controls are decoded from the
//                state, the opcode class and the memory/branch handshakes.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_fetch,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [2:0]  imm_type,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        illegal
);

  state_t     r_state;
  state_t     w_next_state;
  logic       r_illegal;

  logic [3:0] w_class_bits;
  op_class_t  w_class;
  logic [2:0] w_dec_imm_type;
  logic       w_dec_illegal;

  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_mem_fetch;
  logic       w_ir_we;
  logic       w_pc_we;
  logic       w_rf_we;

  ctrl_opcode_decode u_decode (
    .i_opcode   (inst[6:0]),
    .o_class    (w_class_bits),
    .o_imm_type (w_dec_imm_type),
    .o_illegal  (w_dec_illegal)
  );

  assign w_class = op_class_t'(w_class_bits);

  // State register and sticky illegal flag, both cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_DECODE && w_dec_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Next-state and control decode, defaults first
  always_comb begin
    w_next_state = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_fetch  = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_rf_we      = 1'b0;
    pc_src       = c_PC_PLUS4;
    imm_type     = c_IMM_NONE;
    alu_src_a    = c_ALUA_RS1;
    alu_src_b    = c_ALUB_RS2;
    wb_sel       = c_WB_ALU;

    // Immediate format is valid once the instruction is in the IR
    if (r_state == ST_DECODE || r_state == ST_EXEC ||
        r_state == ST_MEM    || r_state == ST_WB) begin
      imm_type = w_dec_imm_type;
    end

    // ALU operands are held through EXEC, MEM and WB so the result stays stable
    if (r_state == ST_EXEC || r_state == ST_MEM || r_state == ST_WB) begin
      case (w_class)
        CLS_OPIMM, CLS_LOAD, CLS_STORE, CLS_JALR: alu_src_b = c_ALUB_IMM;
        CLS_LUI: begin
          alu_src_a = c_ALUA_ZERO;
          alu_src_b = c_ALUB_IMM;
        end
        CLS_AUIPC: begin
          alu_src_a = c_ALUA_PC;
          alu_src_b = c_ALUB_IMM;
        end
        default: ;
      endcase
    end

    case (r_state)
      ST_FETCH: begin
        w_mem_req   = 1'b1;
        w_mem_fetch = 1'b1;
        if (mem_ready) begin
          w_ir_we      = 1'b1;
          w_pc_we      = 1'b1;
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_next_state = w_dec_illegal ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        if (w_class == CLS_BRANCH) begin
          w_pc_we      = branch_taken;
          pc_src       = c_PC_BRANCH;
          w_next_state = ST_FETCH;
        end else if (is_mem_class(w_class)) begin
          w_next_state = ST_MEM;
        end else begin
          w_next_state = ST_WB;
        end
      end
      ST_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (w_class == CLS_STORE);
        if (mem_ready) begin
          w_next_state = (w_class == CLS_STORE) ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        w_rf_we      = 1'b1;
        w_next_state = ST_FETCH;
        case (w_class)
          CLS_LOAD: wb_sel = c_WB_MEM;
          CLS_JAL: begin
            wb_sel  = c_WB_PC4;
            w_pc_we = 1'b1;
            pc_src  = c_PC_BRANCH;
          end
          CLS_JALR: begin
            wb_sel  = c_WB_PC4;
            w_pc_we = 1'b1;
            pc_src  = c_PC_ALU;
          end
          default: wb_sel = c_WB_ALU;
        endcase
      end
      ST_TRAP: begin
        w_next_state = ST_TRAP;
      end
      default: begin
        w_next_state = ST_FETCH;
      end
    endcase
  end

  // Strobes are forced low while reset is held so nothing escapes mid-reset
  assign mem_req   = w_mem_req   & ~rst;
  assign mem_we    = w_mem_we    & ~rst;
  assign mem_fetch = w_mem_fetch & ~rst;
  assign ir_we     = w_ir_we     & ~rst;
  assign pc_we     = w_pc_we     & ~rst;
  assign rf_we     = w_rf_we     & ~rst;
  assign state     = r_state;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire
